// File: rtl/xbar_push_arbiter.sv
// Round-robin, packet-locked arbiter feeding the tx side of one crossbar-output FIFO.
// A grant is held from first beat to last beat, or until the stall watchdog frees it.
module xbar_push_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int STALL_LIMIT = 16,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          fifo_full,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          stall_release
);

  localparam int CW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [CW-1:0] LIMIT_M1 = CW'(STALL_LIMIT - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t              state_q;
  logic [GW-1:0]       grant_q;
  logic [GW-1:0]       last_grant_q;
  logic [GW-1:0]       grant_d;
  logic [CW-1:0]       stall_cnt_q;
  logic                stall_rel_q;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                own_valid;
  logic                own_last;

  // First set bit strictly after 'last', wrapping; the nearest candidate wins.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0]      last);
    logic [GW-1:0] pick;
    logic [GW-1:0] cand;
    pick = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = GW'((int'(last) + i) % NUM_REQ);
      if (v[cand]) pick = cand;
    end
    return pick;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == LIMIT_M1) ? v : v + CW'(1);
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign own_valid     = req_valid[grant_q];
  assign own_last      = req_last[grant_q];
  assign grant_d       = rr_pick(req_valid, last_grant_q);
  assign busy          = (state_q == S_BURST);
  assign fifo_push     = busy & own_valid & ~fifo_full;
  assign fifo_data     = data_arr[grant_q];
  assign grant_id      = grant_q;
  assign stall_release = stall_rel_q;

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_q] = ~fifo_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      stall_cnt_q  <= '0;
      stall_rel_q  <= 1'b0;
    end else begin
      stall_rel_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            grant_q     <= grant_d;
            state_q     <= S_BURST;
            stall_cnt_q <= '0;
          end
        end
        S_BURST: begin
          // A full FIFO freezes grant and watchdog alike; backpressure is not a stall.
          if (!fifo_full) begin
            if (own_valid) begin
              stall_cnt_q <= '0;
              if (own_last) begin
                state_q      <= S_IDLE;
                last_grant_q <= grant_q;
              end
            end else if (stall_cnt_q == LIMIT_M1) begin
              state_q      <= S_IDLE;
              last_grant_q <= grant_q;
              stall_rel_q  <= 1'b1;
            end else begin
              stall_cnt_q <= sat_inc(stall_cnt_q);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/xbar_push_arbiter.md
Name: xbar_push_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the write (tx) side of one crossbar-output async FIFO between N input requesters.
- Sits entirely in the FIFO's tx clock domain. It muxes the granted requester's data onto the FIFO push port and applies FIFO-full backpressure.
- A packet, from the first beat to the `last` beat, is never interleaved with another requester's beats.
- A stall watchdog releases a grant whose owner stops presenting data mid-packet.

Parameters:
- NUM_REQ, 4: number of requesters, ≥2.
- DATA_WIDTH, 32: beat width; matches the FIFO data width.
- STALL_LIMIT, 16: consecutive idle cycles of the grant owner before forced release, ≥1.
- The width constant GW = $clog2(NUM_REQ) is used in the port list.

Ports:
- clk  in  1  tx-domain clock (the FIFO's clk_tx)
- rst  in  1  reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester beat; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  final beat of packet
- req_ready  out  NUM_REQ  beat accepted this cycle when valid&ready
- fifo_push  out  1  to FIFO push_tx
- fifo_data  out  DATA_WIDTH  to FIFO DI_tx
- fifo_full  in  1  from FIFO full_tx
- grant_id  out  GW  current/last owner index
- busy  out  1  high in BURST state
- stall_release  out  1  one-cycle pulse on watchdog release

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - state=IDLE; grant_id=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
  - stall_cnt=0; stall_release=0.
  - Combinational outputs resolve to fifo_push=0, req_ready=0, busy=0.
  - An assertion mid-burst aborts the packet immediately. No further push occurs; the FIFO contents are untouched.
- IDLE state:
  - req_ready=0, fifo_push=0.
  - If any req_valid is high, the next owner is the first set bit searching from (last_grant+1) mod NUM_REQ upward, with wrap-around.
  - On the next edge: grant_id<=winner, state<=BURST, stall_cnt<=0.
  - Valid-to-first-push latency is 1 cycle.
- BURST state, with g=grant_id:
  - busy=1.
  - req_ready[g]=~fifo_full; all other req_ready=0.
  - fifo_push = req_valid[g] & ~fifo_full.
  - fifo_data = req_data[g] in every cycle of BURST (combinational mux). In IDLE, fifo_data = req_data[grant_id].
- Beat accepted (push) with req_last[g]=1:
  - state<=IDLE, last_grant<=g.
  - New arbitration happens in the following cycle, so there is one bubble cycle between packets.
- Beat accepted with req_last[g]=0: stay in BURST, stall_cnt<=0.
- Stall handling:
  - stall_cnt increments only when req_valid[g]=0.
  - While fifo_full=1, stall_cnt is held: backpressure is never a stall.
  - If stall_cnt==STALL_LIMIT-1 and req_valid[g]=0: state<=IDLE, last_grant<=g, stall_release pulses high for 1 cycle.
  - stall_cnt saturates and never wraps.
- FIFO full: no push, the owner's ready=0, and data must be held by the requester. Grant and counters are held.
- Requester rule: requesters must hold req_data and req_last stable while valid&~ready. The arbiter does not latch data.
- Non-granted requesters are never dropped; they wait with ready=0.
- Round-robin fairness: with all NUM_REQ requesters continuously requesting, each requester is granted once per NUM_REQ grants.

Test Plan:
- Single requester: reset; req_valid[2]=1 with a 3-beat packet 0xA0,0xA1,0xA2 (last on 0xA2), fifo_full=0.
  - Required: grant_id=2 one cycle after valid.
  - fifo_push high 3 consecutive cycles with fifo_data A0,A1,A2.
  - busy falls after A2; req_ready[0,1,3] stay 0 throughout.
- Round-robin: all 4 requesters hold 1-beat packets continuously from reset.
  - Required: grant order 0,1,2,3,0,1.
  - Exactly one push per 2 cycles.
- Packet lock: req 0 sends 4 beats; req 1 asserts valid during beat 2.
  - Required: no req 1 beat is pushed until after req 0's last beat; req 1 is granted next.
- Backpressure: fifo_full=1 for 5 cycles during beat 2 of a 3-beat packet.
  - Required: fifo_push=0 and req_ready[g]=0 for those cycles.
  - Beat 2 is pushed exactly once after full drops; stall_release never pulses.
- Stall watchdog (STALL_LIMIT=16): owner drops valid after beat 1 of a 4-beat packet.
  - Required: stall_release pulses on the 16th idle cycle; busy=0 next.
  - A waiting requester is granted in the following cycle.
- Reset mid-burst: assert rst during beat 2.
  - Required: fifo_push=0 and busy=0 immediately (asynchronous).
  - After release, the first grant goes to the lowest-index valid requester starting from 0.
